dma_irq_scheduler: RTL and testbench
====================================

// Module: dma_irq_scheduler
// PURPOSE
// Sequences buffer-done interrupts from the DMA write path to the PS. Latches per-source
// completion events into a pending register and coalesces them by count or timeout. Drives one
// level IRQ plus a one-cycle strobe, and holds IRQ until software acknowledges.
// Enforces a minimum deassert gap between interrupts. Sits between the DMA write engine and
// the IRQ line / status register (IRQ_STATUS) read by the driver.
// PARAMETERS
// N_SRC         4      number of event sources (ping-pong buffers, error), 1..32
// COALESCE_N    1      enabled event-cycles needed before IRQ asserts, >=1
// TIMEOUT_CYC   1024   cycles after first pending event before IRQ asserts regardless of count, >=1
// HOLDOFF_CYC   16     forced IRQ-low cycles after full ack; 0 = no holdoff
// CNT_W         16     width of EVENT_COUNT and internal timers
// PORTS
// M_AXI_ACLK     in   1      clock, all logic rising-edge
// M_AXI_ARESETN  in   1      reset, asynchronous, active-low
// SRC_EVENT      in   N_SRC  one-cycle completion pulses, one per source
// IRQ_MASK       in   N_SRC  1 = source enabled to raise IRQ
// IRQ_ACK        in   1      one-cycle acknowledge strobe from register block
// IRQ_ACK_BITS   in   N_SRC  pending bits cleared when IRQ_ACK=1 (W1C)
// IRQ            out  1      level interrupt to PS
// IRQ_PULSE      out  1      one-cycle strobe on each IRQ rising edge
// IRQ_STATUS     out  32     pending bits, zero-extended above N_SRC
// EVENT_COUNT    out  CNT_W  enabled event-cycles since last assertion, saturating
// OVERRUN        out  N_SRC  sticky: event arrived on an already-pending bit; cleared by ack of that bit
// BEHAVIOUR
// - Reset (async, ARESETN=0): IRQ=0, IRQ_PULSE=0, IRQ_STATUS=0, EVENT_COUNT=0, OVERRUN=0, FSM=IDLE,
//   timers=0. Reset mid-IRQ drops IRQ at once; nothing is remembered.
// - Pending: pend[i] set on SRC_EVENT[i] regardless of mask. Cleared when IRQ_ACK & IRQ_ACK_BITS[i].
//   Event and ack on the same bit in the same cycle: event wins, bit stays 1, OVERRUN[i] not set.
// - act = |(pend & IRQ_MASK). EVENT_COUNT += 1 per cycle with |(SRC_EVENT & IRQ_MASK).
//   Saturates at 2^CNT_W-1. Cleared on entry to ASSERT.
// - FSM states IDLE, COLLECT, ASSERT, WAIT_ACK, HOLDOFF (all registered):
//   IDLE: act=1 -> COLLECT, load timer=TIMEOUT_CYC-1.
//   COLLECT: EVENT_COUNT>=COALESCE_N or timer==0 -> ASSERT. act=0 (acked while silent) -> IDLE.
//     Otherwise timer decrements. Threshold and timeout in the same cycle: one ASSERT only.
//   ASSERT: IRQ=1, IRQ_PULSE=1 for exactly this cycle -> WAIT_ACK.
//   WAIT_ACK: IRQ=1; after an ack leaves act=0 -> HOLDOFF, or IDLE if HOLDOFF_CYC=0.
//     Partial ack stays here. Mask change dropping act to 0 counts as cleared.
//   HOLDOFF: IRQ=0 for HOLDOFF_CYC cycles, events still latched -> IDLE.
//     Pending work is re-collected from IDLE.
// - Latency (COALESCE_N=1): event sampled at edge t -> pend at t+1 -> COLLECT at t+2 ->
//   IRQ high at t+3.
// - Unmasking an already-pending bit in IDLE starts collection as if a new event arrived.
//   EVENT_COUNT does not increment.
// - IRQ_STATUS is the registered pend; it has the same timing as the pend register.
// STRUCTURE
// - Shared package dma_irq_pkg: state enum (IDLE..HOLDOFF), N_SRC max (32), CNT_W default,
//   saturating-increment function.
// - One sub-module dma_irq_timer: loadable CNT_W down-counter with load/en/zero, shared by the
//   timeout and holdoff phases (they never overlap).
// - Top holds pend/overrun regs, event counter, FSM; outputs driven only from flops.
// TESTING
// - Reset: ARESETN low 3 cycles, SRC_EVENT=4'b1111 -> all outputs 0. Deassert -> FSM IDLE, IRQ=0.
// - Single event, N=1, mask=4'hF: SRC_EVENT=4'b0001 at t -> IRQ=1 at t+3, IRQ_PULSE 1 cycle,
//   IRQ_STATUS=1. Ack bits=1 -> IRQ=0, 16 holdoff cycles.
// - Coalesce N=3, TIMEOUT=1024: events on cycles 0,5,9 -> IRQ at cycle 12, EVENT_COUNT
//   reads 3 before clearing. One event only -> IRQ exactly 1024 cycles into COLLECT.
// - Partial ack: pend=4'b0011, ack 4'b0001 -> IRQ stays 1, STATUS=4'b0010.
//   Ack 4'b0010 -> IRQ falls next cycle.
// - Collision and overrun: event bit1 with ack bit1 same cycle -> STATUS bit1 stays 1.
//   Second event on pending bit2 -> OVERRUN=4'b0100 until bit2 acked.
// - Holdoff re-arm: event during HOLDOFF -> IRQ held 0 for all 16 cycles, then re-asserts
//   3 cycles after IDLE. Mask=0 event -> STATUS set, IRQ never rises.

Source files
------------

// File: rtl/dma_irq_pkg.sv
// Shared types and helpers for the DMA buffer-done interrupt scheduler.
// Holds the FSM state encoding, size limits and the saturating counter step.
package dma_irq_pkg;

    localparam int MAX_SRC   = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ASSERT,
        ST_WAIT_ACK,
        ST_HOLDOFF
    } irq_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dma_irq_timer.sv
// Loadable down-counter shared by the coalesce timeout and the post-ack holdoff.
// Stops at zero; load takes priority over decrement.
module dma_irq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dma_irq_scheduler.sv
// Latches per-source buffer-done events, coalesces them by count or timeout and
// drives a level IRQ (held until software clears all enabled pending bits) plus a strobe.
module dma_irq_scheduler
    import dma_irq_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int COALESCE_N  = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int HOLDOFF_CYC = 16,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             M_AXI_ACLK,
    input  logic             M_AXI_ARESETN,
    input  logic [N_SRC-1:0] SRC_EVENT,
    input  logic [N_SRC-1:0] IRQ_MASK,
    input  logic             IRQ_ACK,
    input  logic [N_SRC-1:0] IRQ_ACK_BITS,
    output logic             IRQ,
    output logic             IRQ_PULSE,
    output logic [31:0]      IRQ_STATUS,
    output logic [CNT_W-1:0] EVENT_COUNT,
    output logic [N_SRC-1:0] OVERRUN
);

    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HO_LOAD = CNT_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
    localparam logic [31:0]      CNT_MAX = 32'({CNT_W{1'b1}});

    irq_state_e       r_state, w_state_nxt;
    logic [N_SRC-1:0] r_pend, r_ovr;
    logic [N_SRC-1:0] w_clr, w_pend_nxt;
    logic [CNT_W-1:0] r_evcnt;
    logic             r_thr, r_irq, r_pulse;
    logic             w_act, w_act_nxt, w_ev_en, w_ent_assert;
    logic             w_t_load, w_t_en, w_t_zero;
    logic [CNT_W-1:0] w_t_val;

    // A new event on a bit beats a same-cycle acknowledge of that bit.
    assign w_clr       = IRQ_ACK ? IRQ_ACK_BITS : '0;
    assign w_pend_nxt  = (r_pend & ~w_clr) | SRC_EVENT;
    assign w_act       = |(r_pend & IRQ_MASK);
    assign w_act_nxt   = |(w_pend_nxt & IRQ_MASK);
    assign w_ev_en     = |(SRC_EVENT & IRQ_MASK);
    assign w_ent_assert = (w_state_nxt == ST_ASSERT);

    dma_irq_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (M_AXI_ACLK),
        .i_rst_n    (M_AXI_ARESETN),
        .i_load     (w_t_load),
        .i_load_val (w_t_val),
        .i_en       (w_t_en),
        .o_zero     (w_t_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_t_load    = 1'b0;
        w_t_en      = 1'b0;
        w_t_val     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_act) begin
                    w_state_nxt = ST_COLLECT;
                    w_t_load    = 1'b1;
                    w_t_val     = TO_LOAD;
                end
            end
            ST_COLLECT: begin
                if (!w_act)
                    w_state_nxt = ST_IDLE;
                else if (r_thr || w_t_zero)
                    w_state_nxt = ST_ASSERT;
                else
                    w_t_en = 1'b1;
            end
            ST_ASSERT: w_state_nxt = ST_WAIT_ACK;
            // Look at the post-ack pending value so IRQ drops the cycle after the ack.
            ST_WAIT_ACK: begin
                if (!w_act_nxt) begin
                    if (HOLDOFF_CYC == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLDOFF;
                        w_t_load    = 1'b1;
                        w_t_val     = HO_LOAD;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (w_t_zero)
                    w_state_nxt = ST_IDLE;
                else
                    w_t_en = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_ovr   <= '0;
            r_evcnt <= '0;
            r_thr   <= 1'b0;
            r_irq   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_ovr   <= (r_ovr & ~w_clr) | (SRC_EVENT & r_pend & ~w_clr);
            if (w_ent_assert)
                r_evcnt <= '0;
            else if (w_ev_en)
                r_evcnt <= CNT_W'(sat_inc(32'(r_evcnt), CNT_MAX));
            // Registered threshold keeps the count-to-IRQ path aligned with the pend path.
            r_thr   <= w_ent_assert ? 1'b0 : (32'(r_evcnt) >= 32'(COALESCE_N));
            r_irq   <= (w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_WAIT_ACK);
            r_pulse <= (w_state_nxt == ST_ASSERT);
        end
    end

    always_comb begin
        IRQ_STATUS = '0;
        IRQ_STATUS[N_SRC-1:0] = r_pend;
    end

    assign IRQ         = r_irq;
    assign IRQ_PULSE   = r_pulse;
    assign EVENT_COUNT = r_evcnt;
    assign OVERRUN     = r_ovr;

endmodule

// File: tb/tb_dma_irq_scheduler.sv
// Directed bench for dma_irq_scheduler: one instance with COALESCE_N=1 and one with
// COALESCE_N=3 share all stimulus; each test checks the instance it targets.
module tb_dma_irq_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ev = '0, mask = '0, ackb = '0;
    logic        ack = 1'b0;

    logic        irq1, pulse1, irq3, pulse3;
    logic [31:0] stat1, stat3;
    logic [15:0] cnt1, cnt3;
    logic [3:0]  ovr1, ovr3;

    int n_chk = 0;
    int n_bad = 0;
    logic hi;

    always #5 clk = ~clk;

    dma_irq_scheduler #(.N_SRC(4), .COALESCE_N(1), .TIMEOUT_CYC(1024), .HOLDOFF_CYC(16), .CNT_W(16)) dut1 (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .SRC_EVENT(ev), .IRQ_MASK(mask),
        .IRQ_ACK(ack), .IRQ_ACK_BITS(ackb), .IRQ(irq1), .IRQ_PULSE(pulse1),
        .IRQ_STATUS(stat1), .EVENT_COUNT(cnt1), .OVERRUN(ovr1));

    dma_irq_scheduler #(.N_SRC(4), .COALESCE_N(3), .TIMEOUT_CYC(1024), .HOLDOFF_CYC(16), .CNT_W(16)) dut3 (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .SRC_EVENT(ev), .IRQ_MASK(mask),
        .IRQ_ACK(ack), .IRQ_ACK_BITS(ackb), .IRQ(irq3), .IRQ_PULSE(pulse3),
        .IRQ_STATUS(stat3), .EVENT_COUNT(cnt3), .OVERRUN(ovr3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] bits);
        ev = bits;
        cyc(1);
        ev = '0;
    endtask

    task automatic ack_bits(input logic [3:0] bits);
        ack = 1'b1;
        ackb = bits;
        cyc(1);
        ack = 1'b0;
        ackb = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ev = 4'b1111;
        ack = 1'b0;
        ackb = '0;
        mask = 4'hF;
        cyc(3);
        chk("rst_irq", {28'd0, irq1, pulse1, irq3, pulse3}, 32'd0);
        chk("rst_stat", stat1 | stat3, 32'd0);
        chk("rst_cnt_ovr", {cnt1, cnt3[11:0], ovr1 | ovr3}, 32'd0);
        ev = '0;
        rst_n = 1'b1;
        cyc(1);
        chk("rst_rel", {30'd0, irq1, irq3}, 32'd0);
    endtask

    initial begin
        #1;
        // Single event, ack, holdoff, re-arm from an event latched during holdoff.
        do_reset();
        pulse(4'b0001);
        chk("a_stat", stat1, 32'd1);
        chk("a_irq_t1", {31'd0, irq1}, 32'd0);
        cyc(1);
        chk("a_irq_t2", {31'd0, irq1}, 32'd0);
        cyc(1);
        chk("a_irq_t3", {30'd0, irq1, pulse1}, 32'd3);
        chk("a_cnt_clr", {16'd0, cnt1}, 32'd0);
        cyc(1);
        chk("a_irq_t4", {30'd0, irq1, pulse1}, 32'd2);
        ack_bits(4'b0001);
        chk("a_ack_irq", {31'd0, irq1}, 32'd0);
        chk("a_ack_stat", stat1, 32'd0);
        hi = irq1;
        cyc(1);
        hi |= irq1;
        pulse(4'b0010);
        chk("a_ho_stat", stat1, 32'd2);
        hi |= irq1;
        repeat (15) begin
            cyc(1);
            hi |= irq1;
        end
        chk("a_ho_low", {31'd0, hi}, 32'd0);
        chk("a_ho_cnt", {16'd0, cnt1}, 32'd1);
        cyc(1);
        chk("a_rearm", {30'd0, irq1, pulse1}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("a_async_rst", {27'd0, irq1, stat1[3:0]}, 32'd0);

        // Partial ack, ack/event collision, overrun.
        do_reset();
        pulse(4'b0011);
        cyc(3);
        chk("b_irq", {31'd0, irq1}, 32'd1);
        chk("b_stat3", stat1, 32'd3);
        ack_bits(4'b0001);
        chk("b_part_irq", {31'd0, irq1}, 32'd1);
        chk("b_part_stat", stat1, 32'd2);
        ev = 4'b0010;
        ack_bits(4'b0010);
        ev = '0;
        chk("b_coll_stat", stat1, 32'd2);
        chk("b_coll_ovr", {28'd0, ovr1}, 32'd0);
        pulse(4'b0100);
        pulse(4'b0100);
        chk("b_ovr", {28'd0, ovr1}, 32'd4);
        chk("b_ovr_stat", stat1, 32'd6);
        ack_bits(4'b0010);
        chk("b_ovr_keep", {27'd0, irq1, ovr1}, 32'h14);
        chk("b_stat4", stat1, 32'd4);
        ack_bits(4'b0100);
        chk("b_clr", {27'd0, irq1, ovr1}, 32'd0);
        chk("b_clr_stat", stat1, 32'd0);

        // Coalesce by count: events on cycles 0, 5, 9 -> IRQ at cycle 12.
        do_reset();
        pulse(4'b0001);
        chk("c_cnt1", {16'd0, cnt3}, 32'd1);
        cyc(4);
        pulse(4'b0001);
        chk("c_cnt2", {16'd0, cnt3}, 32'd2);
        cyc(3);
        pulse(4'b0001);
        chk("c_cnt3", {16'd0, cnt3}, 32'd3);
        cyc(1);
        chk("c_pre", {15'd0, cnt3, irq3}, {15'd0, 16'd3, 1'b0});
        cyc(1);
        chk("c_irq", {30'd0, irq3, pulse3}, 32'd3);
        chk("c_cnt_clr", {16'd0, cnt3}, 32'd0);

        // Coalesce by timeout: one event -> IRQ 1024 cycles into COLLECT.
        do_reset();
        pulse(4'b0001);
        cyc(1024);
        chk("c_to_pre", {31'd0, irq3}, 32'd0);
        chk("c_to_cnt", {16'd0, cnt3}, 32'd1);
        cyc(1);
        chk("c_to_irq", {30'd0, irq3, pulse3}, 32'd3);

        // Masked event latches but never interrupts; unmasking starts a timeout collection.
        do_reset();
        mask = 4'h0;
        pulse(4'b1000);
        chk("d_stat", stat1, 32'd8);
        hi = 1'b0;
        repeat (20) begin
            cyc(1);
            hi |= irq1;
        end
        chk("d_no_irq", {31'd0, hi}, 32'd0);
        chk("d_cnt", {16'd0, cnt1}, 32'd0);
        mask = 4'hF;
        cyc(1024);
        chk("d_unmask_pre", {31'd0, irq1}, 32'd0);
        cyc(1);
        chk("d_unmask_irq", {30'd0, irq1, pulse1}, 32'd3);
        chk("d_unmask_cnt", {16'd0, cnt1}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
